bpsk_carrier_nco: RTL and testbench
===================================

BPSK_CARRIER_NCO -- requirements
Module: bpsk_carrier_nco

Interface
REQ-001 SHALL have parameter N_SAMPLES, default `CARRIER_SAMPLES_PER_PERIOD, the carrier samples per period (power of two, >=4).
REQ-002 SHALL have parameter PERIODS_PER_SYMBOL, default 4, the carrier periods per BPSK symbol (>=1).
REQ-003 SHALL have parameter SAMPLE_WIDTH, default 16, the signed output sample width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-006 SHALL have port phase_in_step, input, $clog2(N_SAMPLES) bits: the unsigned phase offset in carrier steps, as produced by phase_converter.
REQ-007 SHALL have port phase_load, input, 1 bit: a one-cycle strobe that captures phase_in_step.
REQ-008 SHALL have port bit_data, input, 1 bit: the symbol bit to transmit.
REQ-009 SHALL have port bit_valid, input, 1 bit: bit_data is valid.
REQ-010 SHALL have port bit_ready, output, 1 bit: the block accepts bit_data.
REQ-011 SHALL have port sample_out, output, SAMPLE_WIDTH bits, signed: the modulated carrier sample.
REQ-012 SHALL have port sample_valid, output, 1 bit: sample_out is valid.
REQ-013 SHALL have port sample_ready, input, 1 bit: the downstream stage accepts the sample.
REQ-014 SHALL have port symbol_start, output, 1 bit: marks the first sample of each symbol, qualified by sample_valid.

Function
REQ-015 SHALL implement a two-state FSM with states IDLE and RUN; bit handshake = bit_valid & bit_ready; sample handshake = sample_valid & sample_ready.
REQ-016 In IDLE: bit_ready=1 and sample_valid=0; a bit handshake moves the FSM to RUN.
REQ-017 In RUN: sample_valid=1; bit_ready=1 only while the current sample is the last sample of the symbol (idx==N_SAMPLES-1 and per_cnt==PERIODS_PER_SYMBOL-1).
REQ-018 In RUN, a sample handshake SHALL advance idx modulo N_SAMPLES, and advance per_cnt modulo PERIODS_PER_SYMBOL when idx wraps.
REQ-019 On a sample handshake of the last sample, with a bit handshake in the same cycle: SHALL load the new bit and stay in RUN, with no gap cycle.
REQ-020 On a sample handshake of the last sample, without a bit handshake: SHALL go to IDLE.
REQ-021 If sample_ready=0, sample_out, sample_valid, symbol_start and the counters SHALL hold.
REQ-022 Captured phase_in_step SHALL be held pending and applied as offset only at a symbol start (IDLE->RUN, or the RUN->RUN bit load).
REQ-023 If multiple phase_load strobes occur before a symbol start, the last one SHALL win.
REQ-024 A phase_load coinciding with a bit handshake SHALL apply to that symbol.
REQ-025 sample_out SHALL equal pol ? -LUT[(idx+offset) mod N_SAMPLES] : LUT[(idx+offset) mod N_SAMPLES].
REQ-026 LUT[k] SHALL equal round((2^(SAMPLE_WIDTH-1)-1)*sin(2*pi*k/N_SAMPLES)), generated at elaboration; negation SHALL never overflow.
REQ-027 sample_out, sample_valid and symbol_start SHALL be registered; the first sample of a symbol SHALL appear the cycle after the bit handshake.
REQ-028 symbol_start SHALL be 1 exactly when sample_valid=1, idx==0 and per_cnt==0.

Reset
REQ-029 While rst_n=0: FSM=IDLE, idx=0, per_cnt=0, offset=0, pending offset=0, pol=0, sample_out=0, sample_valid=0, symbol_start=0.
REQ-030 bit_ready SHALL be 1 immediately after reset is released.
REQ-031 Reset asserted mid-symbol SHALL abort the symbol with no further samples emitted.

Configuration
REQ-032 With macro BPSK_DIFF_ENCODE_EN defined, pol SHALL become pol_prev XOR bit_data at each bit load, and pol_prev SHALL reset to 0.
REQ-033 Without BPSK_DIFF_ENCODE_EN, pol SHALL equal bit_data directly.

Verification (N_SAMPLES=16, PERIODS_PER_SYMBOL=4, SAMPLE_WIDTH=16)
REQ-034 Reset release, bit_data=0 accepted, sample_ready=1 -> next cycle sample_out=0 with symbol_start=1; 5th sample=32767; 13th sample=-32767; 64 samples total; then IDLE.
REQ-035 Back-to-back bits 0 then 1 with bit_valid held -> sample 65=0 with symbol_start=1, sample 69=-32767, no bubble in sample_valid.
REQ-036 phase_load with phase_in_step=4 mid-symbol -> current symbol unchanged; the next symbol's first sample=32767.
REQ-037 sample_ready toggled 0/1 every cycle -> identical 64-sample sequence, outputs stable while stalled.
REQ-038 rst_n pulsed low at sample 20 -> sample_valid=0 asynchronously; after release, a new bit restarts at idx 0.
REQ-039 With BPSK_DIFF_ENCODE_EN, bits 1,1,0 -> symbol polarities negative, positive, positive (5th samples -32767, 32767, 32767).

Source files
------------

// File: rtl/bpsk_carrier_nco.sv
// BPSK carrier NCO: a sine-LUT carrier whose polarity carries one bit per PERIODS_PER_SYMBOL periods.
// Define BPSK_DIFF_ENCODE_EN to differentially encode the polarity (pol = pol_prev ^ bit_data).
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 16
`endif

module bpsk_carrier_nco #(
    parameter int N_SAMPLES          = `CARRIER_SAMPLES_PER_PERIOD,
    parameter int PERIODS_PER_SYMBOL = 4,
    parameter int SAMPLE_WIDTH       = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [$clog2(N_SAMPLES)-1:0]   phase_in_step,
    input  logic                           phase_load,
    input  logic                           bit_data,
    input  logic                           bit_valid,
    output logic                           bit_ready,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           sample_valid,
    input  logic                           sample_ready,
    output logic                           symbol_start
);
    localparam int IW = $clog2(N_SAMPLES);
    localparam int PW = (PERIODS_PER_SYMBOL > 1) ? $clog2(PERIODS_PER_SYMBOL) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_SAMPLES - 1);
    localparam logic [PW-1:0] LAST_PER = PW'(PERIODS_PER_SYMBOL - 1);

    typedef enum logic {IDLE, RUN} state_t;

    // Amplitude is 2^(W-1)-1 so that negating any entry stays in range.
    function automatic logic signed [SAMPLE_WIDTH-1:0] sin_entry(input int k);
        real amp;
        real a;
        int  r;
        amp = (2.0 ** (SAMPLE_WIDTH - 1)) - 1.0;
        a   = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(N_SAMPLES));
        r   = (a >= 0.0) ? $rtoi(a + 0.5) : $rtoi(a - 0.5);
        return SAMPLE_WIDTH'(r);
    endfunction

    logic signed [SAMPLE_WIDTH-1:0] lut [N_SAMPLES];

    for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_lut
        assign lut[gi] = sin_entry(gi);
    end

    state_t                         state_q, state_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [PW-1:0]                  per_q, per_d;
    logic [IW-1:0]                  offset_q, offset_d;
    logic [IW-1:0]                  pending_q, pending_d;
    logic                           pol_q, pol_d;
    logic signed [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic                           valid_q, valid_d;
    logic                           start_q, start_d;
    logic                           last_sample, bit_hs, sample_hs, load_sym;
    logic [IW-1:0]                  lut_idx;

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign symbol_start = start_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        per_d     = per_q;
        offset_d  = offset_q;
        pol_d     = pol_q;
        pending_d = phase_load ? phase_in_step : pending_q;
        load_sym  = 1'b0;

        // A new bit is only taken when the final sample is consumed in the same cycle,
        // so a stalled last sample never loses the bit that follows it.
        last_sample = (idx_q == LAST_IDX) && (per_q == LAST_PER);
        bit_ready   = (state_q == IDLE) || (last_sample && sample_ready);
        bit_hs      = bit_valid && bit_ready;
        sample_hs   = valid_q && sample_ready;

        case (state_q)
            IDLE: begin
                if (bit_hs) begin
                    state_d  = RUN;
                    load_sym = 1'b1;
                end
            end
            RUN: begin
                if (sample_hs) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        per_d = (per_q == LAST_PER) ? '0 : per_q + PW'(1);
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                    if (last_sample) begin
                        if (bit_hs) begin
                            load_sym = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_sym) begin
            idx_d    = '0;
            per_d    = '0;
            offset_d = pending_d;
`ifdef BPSK_DIFF_ENCODE_EN
            pol_d    = pol_q ^ bit_data;
`else
            pol_d    = bit_data;
`endif
        end

        // Outputs are computed from next-state values so the registers track the counters.
        lut_idx  = idx_d + offset_d;
        valid_d  = (state_d == RUN);
        start_d  = valid_d && (idx_d == '0) && (per_d == '0);
        sample_d = '0;
        if (valid_d) begin
            sample_d = pol_d ? -lut[lut_idx] : lut[lut_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            per_q     <= '0;
            offset_q  <= '0;
            pending_q <= '0;
            pol_q     <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            per_q     <= per_d;
            offset_q  <= offset_d;
            pending_q <= pending_d;
            pol_q     <= pol_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
        end
    end

endmodule

// File: tb/tb_bpsk_carrier_nco.sv
// Bench for bpsk_carrier_nco: symbol-level vector table, directed corner sequences and
// randomized traffic checked against a sample-queue reference model.
module tb_bpsk_carrier_nco;
    localparam int NS  = 16;
    localparam int PPS = 4;
    localparam int SW  = 16;
    localparam int SYM = NS * PPS;

    logic                 clk;
    logic                 rst_n;
    logic [3:0]           phase_in_step;
    logic                 phase_load;
    logic                 bit_data;
    logic                 bit_valid;
    logic                 bit_ready;
    logic signed [SW-1:0] sample_out;
    logic                 sample_valid;
    logic                 sample_ready;
    logic                 symbol_start;

    bpsk_carrier_nco #(
        .N_SAMPLES(NS),
        .PERIODS_PER_SYMBOL(PPS),
        .SAMPLE_WIDTH(SW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .phase_in_step(phase_in_step),
        .phase_load(phase_load),
        .bit_data(bit_data),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .sample_out(sample_out),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .symbol_start(symbol_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference carrier table straight from round(32767*sin(2*pi*k/16)).
    int lut_ref [NS];

    function automatic int ref_val(input int i, input int off, input logic pol);
        int v;
        v = lut_ref[(i + off) % NS];
        return pol ? -v : v;
    endfunction

    // Reference model: every accepted bit appends one symbol's worth of expected samples.
    typedef struct {
        int   s;
        logic st;
    } exp_t;
    exp_t expq[$];
    int   m_pend = 0;
    logic m_polprev = 1'b0;

    initial begin
        logic                 stall_prev;
        logic signed [SW-1:0] hold_s;
        logic                 hold_st;
        logic                 pol;
        exp_t                 e;
        stall_prev = 1'b0;
        hold_s     = '0;
        hold_st    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expq.delete();
                m_pend     = 0;
                m_polprev  = 1'b0;
                stall_prev = 1'b0;
                chk("rst_valid", longint'(sample_valid), 0);
                chk("rst_start", longint'(symbol_start), 0);
                chk("rst_sample", longint'(sample_out), 0);
            end else begin
                chk("valid", longint'(sample_valid), longint'(expq.size() != 0));
                chk("bit_ready", longint'(bit_ready),
                    longint'(expq.size() == 0 || (expq.size() == 1 && sample_ready)));
                if (stall_prev) begin
                    chk("hold_sample", longint'(sample_out), longint'(hold_s));
                    chk("hold_start", longint'(symbol_start), longint'(hold_st));
                end
                if (sample_valid && sample_ready && expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("sample", longint'(sample_out), longint'(e.s));
                    chk("sym_start", longint'(symbol_start), longint'(e.st));
                end
                stall_prev = sample_valid && !sample_ready;
                hold_s     = sample_out;
                hold_st    = symbol_start;
                if (phase_load) m_pend = int'(phase_in_step);
                if (bit_valid && bit_ready) begin
`ifdef BPSK_DIFF_ENCODE_EN
                    pol       = m_polprev ^ bit_data;
                    m_polprev = pol;
`else
                    pol       = bit_data;
`endif
                    for (int i = 0; i < SYM; i++) begin
                        e.s  = ref_val(i, m_pend, pol);
                        e.st = (i == 0);
                        expq.push_back(e);
                    end
                end
            end
        end
    end

    logic signed [SW-1:0] cap_s  [SYM];
    logic                 cap_st [SYM];

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic offer_bit(input logic b, input logic ld, input logic [3:0] ph);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        bit_valid     = 1'b1;
        bit_data      = b;
        phase_load    = ld;
        phase_in_step = ph;
        while (!bit_ready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!bit_ready) chk("offer_timeout", 0, 1);
        @(posedge clk);
        #1;
        bit_valid  = 1'b0;
        phase_load = 1'b0;
    endtask

    task automatic collect(input int n, input int budget);
        int got;
        int t;
        got = 0;
        t   = 0;
        while (got < n && t < budget) begin
            @(negedge clk);
            t++;
            if (sample_valid && sample_ready) begin
                cap_s[got]  = sample_out;
                cap_st[got] = symbol_start;
                got++;
            end
        end
        chk("collect_count", longint'(got), longint'(n));
    endtask

    typedef struct {
        logic                 b;
        logic [3:0]           ph;
        int                   k;
        logic signed [SW-1:0] exp_s;
        logic                 exp_st;
    } vec_t;
    vec_t vt[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   got;
        int   t;
        int   bad;
        int   starts;
        real  a;
        vec_t v;

        for (int k = 0; k < NS; k++) begin
            a = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(NS));
            lut_ref[k] = (a >= 0.0) ? $rtoi(a + 0.5) : $rtoi(a - 0.5);
        end

`ifdef BPSK_DIFF_ENCODE_EN
        vt.push_back('{1'b1, 4'd0, 4, -16'sd32767, 1'b0});
        vt.push_back('{1'b1, 4'd0, 4,  16'sd32767, 1'b0});
        vt.push_back('{1'b0, 4'd0, 4,  16'sd32767, 1'b0});
        vt.push_back('{1'b0, 4'd0, 0,  16'sd0,     1'b1});
`else
        vt.push_back('{1'b0, 4'd0,  0,  16'sd0,     1'b1});
        vt.push_back('{1'b0, 4'd0,  4,  16'sd32767, 1'b0});
        vt.push_back('{1'b0, 4'd0,  12, -16'sd32767, 1'b0});
        vt.push_back('{1'b1, 4'd0,  4,  -16'sd32767, 1'b0});
        vt.push_back('{1'b0, 4'd4,  0,  16'sd32767, 1'b1});
        vt.push_back('{1'b1, 4'd4,  0,  -16'sd32767, 1'b1});
        vt.push_back('{1'b0, 4'd8,  4,  -16'sd32767, 1'b0});
        vt.push_back('{1'b1, 4'd12, 0,  16'sd32767, 1'b1});
        vt.push_back('{1'b0, 4'd0,  16, 16'sd0,     1'b0});
        vt.push_back('{1'b1, 4'd0,  60, 16'sd32767, 1'b0});
`endif

        rst_n         = 1'b0;
        phase_in_step = '0;
        phase_load    = 1'b0;
        bit_data      = 1'b0;
        bit_valid     = 1'b0;
        sample_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_sample", longint'(sample_out), 0);
        chk("reset_valid", longint'(sample_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("ready_after_reset", longint'(bit_ready), 1);

        // Basic symbol: latency, key samples, symbol count, return to idle.
        offer_bit(1'b0, 1'b1, 4'd0);
        chk("first_valid", longint'(sample_valid), 1);
        chk("first_start", longint'(symbol_start), 1);
        chk("first_sample", longint'(sample_out), 0);
        collect(SYM, SYM);
        chk("basic_s4", longint'(cap_s[4]), 32767);
        chk("basic_s12", longint'(cap_s[12]), -32767);
        starts = 0;
        for (int i = 0; i < SYM; i++) starts += int'(cap_st[i]);
        chk("basic_starts", longint'(starts), 1);
        @(posedge clk);
        #1;
        chk("basic_idle_valid", longint'(sample_valid), 0);

        // Vector table: one isolated symbol per row.
        do_reset();
        for (int r = 0; r < vt.size(); r++) begin
            v = vt[r];
            offer_bit(v.b, 1'b1, v.ph);
            collect(SYM, SYM);
            chk($sformatf("vec%0d_sample", r), longint'(cap_s[v.k]), longint'(v.exp_s));
            chk($sformatf("vec%0d_start", r), longint'(cap_st[v.k]), longint'(v.exp_st));
        end

        // Back-to-back bits with bit_valid held: no bubble between symbols.
        do_reset();
        @(posedge clk);
        #1;
        bit_valid     = 1'b1;
        bit_data      = 1'b0;
        phase_load    = 1'b1;
        phase_in_step = 4'd0;
        @(posedge clk);
        #1;
        phase_load = 1'b0;
        bit_data   = 1'b1;
        collect(SYM, SYM);
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        collect(SYM, SYM);
        chk("b2b_s65", longint'(cap_s[0]), 0);
        chk("b2b_s65_start", longint'(cap_st[0]), 1);
        chk("b2b_s69", longint'(cap_s[4]), -32767);

        // Phase load mid-symbol takes effect only at the next symbol.
        do_reset();
        offer_bit(1'b0, 1'b0, 4'd0);
        collect(20, 20);
        @(posedge clk);
        #1;
        phase_load    = 1'b1;
        phase_in_step = 4'd4;
        @(posedge clk);
        #1;
        phase_load = 1'b0;
        collect(43, 43);
        chk("midload_current_s28", longint'(cap_s[7]), -32767);
        offer_bit(1'b0, 1'b0, 4'd0);
        collect(SYM, SYM);
        chk("midload_next_s0", longint'(cap_s[0]), 32767);
        chk("midload_next_s8", longint'(cap_s[8]), -32767);

        // Stalls every other cycle: same sequence, outputs held while stalled.
        do_reset();
        sample_ready = 1'b0;
        offer_bit(1'b0, 1'b1, 4'd0);
        got = 0;
        t   = 0;
        while (got < SYM && t < 300) begin
            @(negedge clk);
            t++;
            if (sample_valid && sample_ready) begin
                cap_s[got] = sample_out;
                got++;
            end
            @(posedge clk);
            #1;
            sample_ready = ~sample_ready;
        end
        chk("stall_count", longint'(got), SYM);
        bad = 0;
        for (int i = 0; i < got; i++) begin
            if (int'(cap_s[i]) != ref_val(i, 0, 1'b0)) bad++;
        end
        chk("stall_seq_errors", longint'(bad), 0);
        sample_ready = 1'b1;

        // Reset mid-symbol aborts output immediately; next bit restarts at idx 0.
        do_reset();
        offer_bit(1'b0, 1'b1, 4'd0);
        collect(20, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", longint'(sample_valid), 0);
        chk("async_rst_start", longint'(symbol_start), 0);
        chk("async_rst_sample", longint'(sample_out), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("ready_after_release", longint'(bit_ready), 1);
        offer_bit(1'b1, 1'b0, 4'd0);
        collect(SYM, SYM);
        chk("restart_s0", longint'(cap_s[0]), 0);
        chk("restart_start", longint'(cap_st[0]), 1);
        chk("restart_s4", longint'(cap_s[4]), -32767);

        // Randomized traffic against the reference queue.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            bit_valid     = ($urandom_range(0, 3) != 0);
            bit_data      = 1'($urandom_range(0, 1));
            phase_load    = ($urandom_range(0, 15) == 0);
            phase_in_step = 4'($urandom_range(0, 15));
            sample_ready  = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        bit_valid    = 1'b0;
        phase_load   = 1'b0;
        sample_ready = 1'b1;
        t = 0;
        while (expq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", longint'(expq.size()), 0);
        @(negedge clk);
        chk("drain_idle", longint'(sample_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
